sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Two-master arbiter sharing the single SDRAM controller slave port.
- Master 0 is the VGA line-fetch reader (read-only, high priority). Master 1 is the game draw/CPU path (read and write).
- Command path is pipelined Avalon-MM style with waitrequest. Read responses are routed back to their issuer through an in-order tag FIFO.
- Includes a starvation guard so master 1 is guaranteed service during long display bursts.

Parameters:
ADDR_W, 24, word address width (16M x 16-bit SDRAM)
DATA_W, 16, data width; byteenable width = DATA_W/8
MAX_PENDING, 8, max outstanding reads (tag FIFO depth, power of 2)
MAX_M0_RUN, 16, max consecutive m0 grants while m1 is waiting

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous active-high reset
m0_address  in  ADDR_W  VGA read address
m0_read  in  1  VGA read request
m0_waitrequest  out  1  stall to m0
m0_readdata  out  DATA_W  read data to m0
m0_readdatavalid  out  1  m0 read data valid
m1_address  in  ADDR_W  draw address
m1_read  in  1  draw read request
m1_write  in  1  draw write request
m1_writedata  in  DATA_W  draw write data
m1_byteenable  in  DATA_W/8  draw byte enables
m1_waitrequest  out  1  stall to m1
m1_readdata  out  DATA_W  read data to m1
m1_readdatavalid  out  1  m1 read data valid
s_address  out  ADDR_W  to SDRAM controller
s_read  out  1  to SDRAM controller
s_write  out  1  to SDRAM controller
s_writedata  out  DATA_W  to SDRAM controller
s_byteenable  out  DATA_W/8  to SDRAM controller; all-ones for m0
s_waitrequest  in  1  controller stall
s_readdata  in  DATA_W  controller read data
s_readdatavalid  in  1  controller read data valid
pending_count  out  log2(MAX_PENDING)+1  outstanding reads
err_orphan  out  1  sticky: readdatavalid seen with empty tag FIFO

Behaviour:
- Clock and reset: one clock, clk_clk. Reset reset_reset is synchronous and active-high.
- Reset values: lock=0, owner=0, starve_cnt=0, FIFO empty, pending_count=0, err_orphan=0. All s_* command outputs are 0 during reset. Both waitrequests are 1 during reset.
- Request signals: req0=m0_read; req1=m1_read|m1_write.
- A read is blocked when pending_count==MAX_PENDING. The check uses the registered count, so a pop in the same cycle does not unblock it. Writes are never blocked by the count.
- Arbitration when unlocked (combinational):
  - m1 wins if req1 and (starve_cnt==MAX_M0_RUN or !req0).
  - Otherwise m0 wins if req0.
  - A master whose request is blocked is treated as not requesting.
- Lock: a presented command with s_waitrequest=1 sets lock and holds owner. Command outputs then come from owner until accepted. Masters must hold their signals while their waitrequest is 1.
- Acceptance: a command is accepted when it is presented and s_waitrequest=0. Acceptance clears lock.
- Loser's waitrequest is 1. A master's waitrequest is 0 only in the cycle its command is accepted; otherwise it is 1 whenever it requests and does not win. Idle master: waitrequest=1.
- Command path adds zero cycles: the s_* outputs are a combinational mux of the winning master.
- No command presented: s_read=s_write=0.
- Tag FIFO:
  - An accepted read pushes the owner id.
  - s_readdatavalid pops the head and asserts m<head>_readdatavalid in the same cycle.
  - s_readdata is fanned out to both m*_readdata.
  - Push and pop in the same cycle leave the count unchanged.
- Orphan response: s_readdatavalid with an empty FIFO drops the data, asserts neither m*_readdatavalid, and sets err_orphan. err_orphan is cleared only by reset.
- starve_cnt:
  - Increments (saturating at MAX_M0_RUN) on each m0 acceptance while req1=1.
  - Cleared on m1 acceptance, or in any cycle with req1=0.
- Reset mid-transaction: lock and FIFO are cleared. Any later responses from in-flight reads count as orphans.
- m1 with read and write both asserted is illegal. It is treated as a write and s_read is driven 0.

Test Plan:
- Idle, m0_read at addr 0x000100, s_waitrequest=0 -> s_read=1 and s_address=0x000100 in the same cycle; m0_waitrequest=0. s_readdatavalid 3 cycles later with data 0xABCD -> m0_readdatavalid=1, m0_readdata=0xABCD, m1_readdatavalid=0.
- m0 and m1 requesting together with s_waitrequest held 1 for 4 cycles -> s_address stays at m0's address for all 4 cycles, m1_waitrequest=1 throughout. Drop s_waitrequest -> m0 accepted, then m1 granted the next cycle.
- m0 reading continuously, m1 write 0x1234 pending, s_waitrequest=0 -> exactly 16 m0 acceptances, then the m1 write is accepted (s_write=1, s_writedata=0x1234), then m0 resumes.
- Interleaved reads m0, m1, m0, m1 with responses returned in order -> readdatavalid alternates m0, m1, m0, m1 with the matching data; pending_count goes 4 -> 0.
- 8 reads issued and no responses -> pending_count=8, 9th read held with waitrequest=1, a write still accepted. One response -> the 9th read is accepted the following cycle.
- s_readdatavalid with empty FIFO -> err_orphan=1 and stays set; reset_reset for 1 cycle -> err_orphan=0 and pending_count=0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter in front of a single SDRAM controller slave port.
// m0 (VGA line fetch, read-only) has priority; m1 (draw/CPU) is guaranteed a
// slot after MAX_M0_RUN back-to-back m0 acceptances. Read responses are steered
// back to their issuer through an in-order tag FIFO.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_PENDING = 8,
  parameter int unsigned MAX_M0_RUN  = 16
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  // master 0: VGA reader
  input  logic [ADDR_W-1:0]            m0_address,
  input  logic                         m0_read,
  output logic                         m0_waitrequest,
  output logic [DATA_W-1:0]            m0_readdata,
  output logic                         m0_readdatavalid,
  // master 1: draw / CPU
  input  logic [ADDR_W-1:0]            m1_address,
  input  logic                         m1_read,
  input  logic                         m1_write,
  input  logic [DATA_W-1:0]            m1_writedata,
  input  logic [DATA_W/8-1:0]          m1_byteenable,
  output logic                         m1_waitrequest,
  output logic [DATA_W-1:0]            m1_readdata,
  output logic                         m1_readdatavalid,
  // slave: SDRAM controller
  output logic [ADDR_W-1:0]            s_address,
  output logic                         s_read,
  output logic                         s_write,
  output logic [DATA_W-1:0]            s_writedata,
  output logic [DATA_W/8-1:0]          s_byteenable,
  input  logic                         s_waitrequest,
  input  logic [DATA_W-1:0]            s_readdata,
  input  logic                         s_readdatavalid,
  // status
  output logic [$clog2(MAX_PENDING):0] pending_count,
  output logic                         err_orphan
);

  localparam int unsigned PTR_W = $clog2(MAX_PENDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RUN_W = $clog2(MAX_M0_RUN + 1);

  // Arbitration state
  logic             lock_q;
  logic             owner_q;
  logic [RUN_W-1:0] starve_q;

  // Tag FIFO: one bit per outstanding read, 0 = m0, 1 = m1
  logic             tag_q [MAX_PENDING];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             orphan_q;

  logic rd_full;
  logic want0;
  logic want1;
  logic m1_is_rd;
  logic present;
  logic sel;
  logic accept;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head;

  // Read blocking uses the registered count, so a same-cycle pop does not help.
  assign rd_full    = (count_q == CNT_W'(MAX_PENDING));
  assign m1_is_rd   = m1_read & ~m1_write;  // read+write together counts as a write
  assign want0      = m0_read & ~rd_full;
  assign want1      = m1_write | (m1_read & ~rd_full);
  assign fifo_empty = (count_q == '0);

  // Pick the master presented to the slave this cycle.
  always_comb begin
    present = 1'b0;
    sel     = 1'b0;
    if (reset_reset) begin
      present = 1'b0;
    end else if (lock_q) begin
      // A stalled command keeps the port until the controller takes it.
      sel     = owner_q;
      present = owner_q ? (m1_read | m1_write) : m0_read;
    end else if (want1 && ((starve_q == RUN_W'(MAX_M0_RUN)) || !want0)) begin
      sel     = 1'b1;
      present = 1'b1;
    end else if (want0) begin
      present = 1'b1;
    end
  end

  assign accept = present & ~s_waitrequest;

  // Zero-latency command mux and per-master stall.
  always_comb begin
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    if (present) begin
      if (sel) begin
        s_address    = m1_address;
        s_read       = m1_is_rd;
        s_write      = m1_write;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
      end else begin
        s_address    = m0_address;
        s_read       = 1'b1;
        s_byteenable = '1;
      end
    end
    m0_waitrequest = ~(accept & ~sel);
    m1_waitrequest = ~(accept & sel);
  end

  assign push = accept & s_read;
  assign head = tag_q[rptr_q];
  assign pop  = s_readdatavalid & ~fifo_empty & ~reset_reset;

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;
  assign pending_count    = count_q;
  assign err_orphan       = orphan_q;

  // Lock, starvation counter, FIFO pointers and the sticky orphan flag.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      lock_q   <= 1'b0;
      owner_q  <= 1'b0;
      starve_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      lock_q <= present & s_waitrequest;
      if (present) begin
        owner_q <= sel;
      end

      if (!want1 || (accept && sel)) begin
        starve_q <= '0;
      end else if (accept && !sel && (starve_q != RUN_W'(MAX_M0_RUN))) begin
        starve_q <= starve_q + RUN_W'(1);
      end

      if (push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if (s_readdatavalid && fifo_empty) begin
        orphan_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset; only entries between the pointers are read.
  always_ff @(posedge clk_clk) begin
    if (push) begin
      tag_q[wptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_sdram_port_arbiter;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned MAXP   = 8;
  localparam int unsigned MAXRUN = 16;

  logic              clk_clk;
  logic              reset_reset;
  logic [ADDR_W-1:0] m0_address;
  logic              m0_read;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;
  logic [ADDR_W-1:0] m1_address;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic [1:0]        m1_byteenable;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;
  logic [ADDR_W-1:0] s_address;
  logic              s_read;
  logic              s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [1:0]        s_byteenable;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic [3:0]        pending_count;
  logic              err_orphan;

  int checks;
  int errors;

  sdram_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_PENDING(MAXP),
    .MAX_M0_RUN (MAXRUN)
  ) dut (
    .clk_clk         (clk_clk),
    .reset_reset     (reset_reset),
    .m0_address      (m0_address),
    .m0_read         (m0_read),
    .m0_waitrequest  (m0_waitrequest),
    .m0_readdata     (m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address      (m1_address),
    .m1_read         (m1_read),
    .m1_write        (m1_write),
    .m1_writedata    (m1_writedata),
    .m1_byteenable   (m1_byteenable),
    .m1_waitrequest  (m1_waitrequest),
    .m1_readdata     (m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .pending_count   (pending_count),
    .err_orphan      (err_orphan)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the falling edge.
  task automatic to_neg();
    #4;
  endtask

  task automatic next_cycle();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_address      = '0;
    m0_read         = 1'b0;
    m1_address      = '0;
    m1_read         = 1'b0;
    m1_write        = 1'b0;
    m1_writedata    = '0;
    m1_byteenable   = '0;
    s_waitrequest   = 1'b0;
    s_readdata      = '0;
    s_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_reset = 1'b1;
    next_cycle();
    reset_reset = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int   tagq[$];
  bit   m_lock, m_owner, m_orphan;
  int   m_starve;
  bit   e_pres, e_sel, e_want1, e_acc;
  bit   e_sread, e_swrite, e_wr0, e_wr1, e_rdv0, e_rdv1;
  logic [ADDR_W-1:0] e_addr;

  task automatic model_comb();
    bit blocked, want0;
    e_pres = 0; e_sel = 0; e_sread = 0; e_swrite = 0; e_want1 = 0; e_acc = 0;
    e_wr0 = 1; e_wr1 = 1; e_rdv0 = 0; e_rdv1 = 0; e_addr = '0;
    if (reset_reset) return;
    blocked = (tagq.size() >= MAXP);
    want0   = m0_read && !blocked;
    e_want1 = m1_write || (m1_read && !blocked);
    if (m_lock) begin
      e_sel  = m_owner;
      e_pres = m_owner ? (m1_read || m1_write) : m0_read;
    end else if (e_want1 && (m_starve == MAXRUN || !want0)) begin
      e_sel = 1; e_pres = 1;
    end else if (want0) begin
      e_sel = 0; e_pres = 1;
    end
    if (e_pres) begin
      e_addr   = e_sel ? m1_address : m0_address;
      e_swrite = e_sel && m1_write;
      e_sread  = !e_swrite;
    end
    e_acc = e_pres && !s_waitrequest;
    e_wr0 = !(e_acc && !e_sel);
    e_wr1 = !(e_acc && e_sel);
    if (s_readdatavalid && tagq.size() > 0) begin
      e_rdv0 = (tagq[0] == 0);
      e_rdv1 = (tagq[0] == 1);
    end
  endtask

  task automatic model_clock();
    if (reset_reset) begin
      tagq.delete(); m_lock = 0; m_owner = 0; m_orphan = 0; m_starve = 0;
      return;
    end
    if (s_readdatavalid) begin
      if (tagq.size() > 0) void'(tagq.pop_front());
      else m_orphan = 1;
    end
    if (e_acc && e_sread) tagq.push_back(int'(e_sel));
    if (e_pres && s_waitrequest) begin
      m_lock = 1; m_owner = e_sel;
    end else begin
      m_lock = 0;
    end
    if (!e_want1 || (e_acc && e_sel)) m_starve = 0;
    else if (e_acc && !e_sel && m_starve < MAXRUN) m_starve++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset_reset = 1'b1;
    m0_read = 1'b1; m0_address = 24'h000123;
    m1_write = 1'b1;
    to_neg();
    checks++;
    if ({s_read, s_write, s_address} !== {1'b0, 1'b0, 24'h0}) begin
      errors++; $display("FAIL reset_cmd got r=%b w=%b a=%h exp 0 0 0", s_read, s_write, s_address);
    end
    checks++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
      errors++; $display("FAIL reset_wait got %b%b exp 11", m0_waitrequest, m1_waitrequest);
    end
    next_cycle();
    reset_reset = 1'b0;
    idle_inputs();
    to_neg();
    checks++;
    if ({pending_count, err_orphan} !== 5'b0) begin
      errors++; $display("FAIL reset_state got pc=%0d orph=%b exp 0 0", pending_count, err_orphan);
    end
    checks++;
    if ({m0_waitrequest, m1_waitrequest, s_read, s_write} !== 4'b1100) begin
      errors++; $display("FAIL idle_out got %b%b%b%b exp 1100",
                         m0_waitrequest, m1_waitrequest, s_read, s_write);
    end
    next_cycle();
  endtask

  task automatic test_basic_read();
    do_reset();
    m0_read = 1'b1; m0_address = 24'h000100;
    to_neg();
    checks++;
    if ({s_read, s_address, m0_waitrequest} !== {1'b1, 24'h000100, 1'b0}) begin
      errors++; $display("FAIL basic_cmd got r=%b a=%h wr=%b exp 1 000100 0",
                         s_read, s_address, m0_waitrequest);
    end
    next_cycle();
    m0_read = 1'b0;
    next_cycle();
    next_cycle();
    s_readdatavalid = 1'b1; s_readdata = 16'hABCD;
    to_neg();
    checks++;
    if ({m0_readdatavalid, m0_readdata, m1_readdatavalid} !== {1'b1, 16'hABCD, 1'b0}) begin
      errors++; $display("FAIL basic_resp got v0=%b d=%h v1=%b exp 1 abcd 0",
                         m0_readdatavalid, m0_readdata, m1_readdatavalid);
    end
    next_cycle();
    s_readdatavalid = 1'b0;
    to_neg();
    checks++;
    if (pending_count !== 4'd0) begin
      errors++; $display("FAIL basic_drain got %0d exp 0", pending_count);
    end
    next_cycle();
  endtask

  task automatic test_lock();
    do_reset();
    m0_read = 1'b1; m0_address = 24'h0A0A0A;
    m1_write = 1'b1; m1_address = 24'h0B0B0B; m1_writedata = 16'h5A5A; m1_byteenable = 2'b01;
    s_waitrequest = 1'b1;
    for (int c = 0; c < 4; c++) begin
      to_neg();
      checks++;
      if ({s_address, m0_waitrequest, m1_waitrequest} !== {24'h0A0A0A, 1'b1, 1'b1}) begin
        errors++; $display("FAIL lock_hold c=%0d got a=%h w0=%b w1=%b exp 0a0a0a 1 1",
                           c, s_address, m0_waitrequest, m1_waitrequest);
      end
      next_cycle();
    end
    s_waitrequest = 1'b0;
    to_neg();
    checks++;
    if ({s_read, s_address, m0_waitrequest, m1_waitrequest} !== {1'b1, 24'h0A0A0A, 1'b0, 1'b1})
    begin
      errors++; $display("FAIL lock_accept got r=%b a=%h w0=%b w1=%b exp 1 0a0a0a 0 1",
                         s_read, s_address, m0_waitrequest, m1_waitrequest);
    end
    next_cycle();
    m0_read = 1'b0;
    to_neg();
    checks++;
    if ({s_write, s_read, s_address, s_writedata, s_byteenable, m1_waitrequest} !==
        {1'b1, 1'b0, 24'h0B0B0B, 16'h5A5A, 2'b01, 1'b0}) begin
      errors++; $display("FAIL lock_m1_next got w=%b r=%b a=%h d=%h be=%b wr1=%b",
                         s_write, s_read, s_address, s_writedata, s_byteenable, m1_waitrequest);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_starvation();
    int outst, m0_acc, gap;
    bit done;
    do_reset();
    m0_read = 1'b1;
    m1_write = 1'b1; m1_address = 24'h002000; m1_writedata = 16'h1234; m1_byteenable = 2'b11;
    outst = 0; m0_acc = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      m0_address = ADDR_W'(24'h100000 + c);
      s_readdatavalid = (outst > 0);
      s_readdata = 16'(c);
      to_neg();
      if (s_readdatavalid) outst--;
      if (!m0_waitrequest) begin
        m0_acc++; outst++;
      end
      if (!m1_waitrequest) begin
        done = 1;
        checks++;
        if (m0_acc !== 16) begin
          errors++; $display("FAIL starve_count got %0d exp 16", m0_acc);
        end
        checks++;
        if ({s_write, s_writedata} !== {1'b1, 16'h1234}) begin
          errors++; $display("FAIL starve_write got w=%b d=%h exp 1 1234", s_write, s_writedata);
        end
      end
      next_cycle();
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL starve_timeout got no m1 grant exp grant within 60 cycles");
    end
    m1_write = 1'b0;
    s_readdatavalid = (outst > 0);
    to_neg();
    gap = m0_waitrequest;
    checks++;
    if ({gap[0], s_read} !== 2'b01) begin
      errors++; $display("FAIL starve_resume got w0=%b r=%b exp 0 1", m0_waitrequest, s_read);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_interleave();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      m0_read = (k % 2 == 0); m0_address = ADDR_W'(k);
      m1_read = (k % 2 == 1); m1_address = ADDR_W'(24'h800 + k);
      to_neg();
      checks++;
      if ({s_read, m0_waitrequest, m1_waitrequest} !== {1'b1, k % 2 == 1, k % 2 == 0}) begin
        errors++; $display("FAIL inter_issue k=%0d got r=%b w0=%b w1=%b", k, s_read,
                           m0_waitrequest, m1_waitrequest);
      end
      next_cycle();
    end
    m0_read = 1'b0; m1_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_readdatavalid = 1'b1; s_readdata = 16'(16'hC000 + k);
      to_neg();
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid, pending_count} !==
          {k % 2 == 0, k % 2 == 1, 4'(4 - k)}) begin
        errors++; $display("FAIL inter_resp k=%0d got v0=%b v1=%b pc=%0d exp v0=%b pc=%0d",
                           k, m0_readdatavalid, m1_readdatavalid, pending_count, k % 2 == 0, 4 - k);
      end
      checks++;
      if (((k % 2 == 0) ? m0_readdata : m1_readdata) !== 16'(16'hC000 + k)) begin
        errors++; $display("FAIL inter_data k=%0d got %h %h exp %h", k, m0_readdata,
                           m1_readdata, 16'hC000 + k);
      end
      next_cycle();
    end
    s_readdatavalid = 1'b0;
    to_neg();
    checks++;
    if (pending_count !== 4'd0) begin
      errors++; $display("FAIL inter_drain got %0d exp 0", pending_count);
    end
    next_cycle();
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      m0_read = 1'b1; m0_address = ADDR_W'(24'h300 + k);
      next_cycle();
    end
    m0_address = 24'h000399;
    m1_write = 1'b1; m1_address = 24'h004000; m1_writedata = 16'hBEEF; m1_byteenable = 2'b10;
    to_neg();
    checks++;
    if (pending_count !== 4'd8) begin
      errors++; $display("FAIL full_count got %0d exp 8", pending_count);
    end
    checks++;
    if ({m0_waitrequest, s_write, s_read, m1_waitrequest} !== 4'b1100) begin
      errors++; $display("FAIL full_write got w0=%b sw=%b sr=%b w1=%b exp 1 1 0 0",
                         m0_waitrequest, s_write, s_read, m1_waitrequest);
    end
    next_cycle();
    m1_write = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 16'h7777;
    to_neg();
    checks++;
    if ({m0_waitrequest, s_read, m0_readdatavalid} !== 3'b101) begin
      errors++; $display("FAIL full_samepop got w0=%b r=%b v0=%b exp 1 0 1",
                         m0_waitrequest, s_read, m0_readdatavalid);
    end
    next_cycle();
    s_readdatavalid = 1'b0;
    to_neg();
    checks++;
    if ({m0_waitrequest, s_read, s_address} !== {1'b0, 1'b1, 24'h000399}) begin
      errors++; $display("FAIL full_unblock got w0=%b r=%b a=%h exp 0 1 000399",
                         m0_waitrequest, s_read, s_address);
    end
    next_cycle();
    m0_read = 1'b0;
    to_neg();
    checks++;
    if (pending_count !== 4'd8) begin
      errors++; $display("FAIL full_refill got %0d exp 8", pending_count);
    end
    next_cycle();
  endtask

  task automatic test_orphan();
    do_reset();
    s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
    to_neg();
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL orphan_drop got %b%b exp 00", m0_readdatavalid, m1_readdatavalid);
    end
    next_cycle();
    s_readdatavalid = 1'b0;
    next_cycle();
    next_cycle();
    to_neg();
    checks++;
    if ({err_orphan, pending_count} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL orphan_sticky got e=%b pc=%0d exp 1 0", err_orphan, pending_count);
    end
    next_cycle();
    // Read in flight across a reset: its response must become an orphan.
    m1_read = 1'b1; m1_address = 24'h00F000;
    next_cycle();
    m1_read = 1'b0;
    reset_reset = 1'b1;
    next_cycle();
    reset_reset = 1'b0;
    to_neg();
    checks++;
    if ({err_orphan, pending_count} !== {1'b0, 4'd0}) begin
      errors++; $display("FAIL orphan_reset got e=%b pc=%0d exp 0 0", err_orphan, pending_count);
    end
    next_cycle();
    s_readdatavalid = 1'b1;
    to_neg();
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL orphan_inflight got %b%b exp 00", m0_readdatavalid, m1_readdatavalid);
    end
    next_cycle();
    s_readdatavalid = 1'b0;
    to_neg();
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++; $display("FAIL orphan_inflight_flag got %b exp 1", err_orphan);
    end
    next_cycle();
  endtask

  task automatic test_random();
    bit m0_hold, m1_hold;
    int r;
    do_reset();
    tagq.delete(); m_lock = 0; m_owner = 0; m_orphan = 0; m_starve = 0;
    m0_hold = 0; m1_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      reset_reset = ($urandom_range(0, 499) == 0);
      if (!m0_hold) begin
        m0_read = ($urandom_range(0, 9) < 6);
        m0_address = ADDR_W'($urandom);
      end
      if (!m1_hold) begin
        r = $urandom_range(0, 19);
        m1_read  = (r >= 8 && r < 13) || r == 19;
        m1_write = (r >= 13);
        m1_address = ADDR_W'($urandom);
        m1_writedata = 16'($urandom);
        m1_byteenable = 2'($urandom);
      end
      s_waitrequest = ($urandom_range(0, 3) == 0);
      s_readdatavalid = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
      s_readdata = 16'($urandom);
      to_neg();
      model_comb();
      checks++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid}
          !== {e_sread, e_swrite, e_wr0, e_wr1, e_rdv0, e_rdv1}) begin
        errors++; $display("FAIL rnd_ctl c=%0d got %b%b%b%b%b%b exp %b%b%b%b%b%b", c,
                           s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid,
                           m1_readdatavalid, e_sread, e_swrite, e_wr0, e_wr1, e_rdv0, e_rdv1);
      end
      if (e_pres) begin
        checks++;
        if (s_address !== e_addr) begin
          errors++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, s_address, e_addr);
        end
        checks++;
        if (e_swrite && {s_writedata, s_byteenable} !== {m1_writedata, m1_byteenable}) begin
          errors++; $display("FAIL rnd_wdata c=%0d got %h/%b exp %h/%b", c, s_writedata,
                             s_byteenable, m1_writedata, m1_byteenable);
        end else if (!e_sel && s_byteenable !== 2'b11) begin
          errors++; $display("FAIL rnd_m0_be c=%0d got %b exp 11", c, s_byteenable);
        end
      end
      if (e_rdv0 || e_rdv1) begin
        checks++;
        if ((e_rdv0 ? m0_readdata : m1_readdata) !== s_readdata) begin
          errors++; $display("FAIL rnd_rdata c=%0d got %h/%h exp %h", c, m0_readdata,
                             m1_readdata, s_readdata);
        end
      end
      checks++;
      if ({pending_count, err_orphan} !== {4'(tagq.size()), m_orphan}) begin
        errors++; $display("FAIL rnd_status c=%0d got pc=%0d e=%b exp pc=%0d e=%b", c,
                           pending_count, err_orphan, tagq.size(), m_orphan);
      end
      m0_hold = m0_read && e_wr0;
      m1_hold = (m1_read || m1_write) && e_wr1;
      model_clock();
      next_cycle();
    end
    reset_reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_reset = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_basic_read();
    test_lock();
    test_starvation();
    test_interleave();
    test_full();
    test_orphan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
